quad_min_loader: RTL and testbench



---
 rtl/quad_min_loader.sv | 110 +++++++++++
 tb/tb_quad_min_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_min_loader.sv
// Packs four serial samples into a..d for the returnmin stage and captures its result.
// Optional QUAD_MIN_LOADER_CHECK_EN adds chk_err, flagging an inconsistent minidx_in.
module quad_min_loader #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    input  logic [1:0]   minidx_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_idx,
`ifdef QUAD_MIN_LOADER_CHECK_EN
    output logic [W-1:0] out_min,
    output logic         chk_err
`else
    output logic [W-1:0] out_min
`endif
);

    typedef enum logic [1:0] {FILL, EVAL, HOLD} state_t;

    state_t       state_q;
    logic [1:0]   cnt_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [1:0]   out_idx_q;
    logic [W-1:0] out_min_q;
    logic [W-1:0] smp_q [4];
    logic [W-1:0] sel_val;

    assign sel_val = smp_q[minidx_in];

`ifdef QUAD_MIN_LOADER_CHECK_EN
    // The selected value must not exceed any of the four registers.
    logic [3:0] gt_vec;
    logic       chk_err_q;
    for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
        assign gt_vec[gi] = (sel_val > smp_q[gi]);
    end
    assign chk_err = chk_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= 2'd0;
            out_min_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                smp_q[i] <= '0;
            end
`ifdef QUAD_MIN_LOADER_CHECK_EN
            chk_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        smp_q[cnt_q] <= in_data;
                        cnt_q        <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q    <= EVAL;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                EVAL: begin
                    out_idx_q   <= minidx_in;
                    out_min_q   <= sel_val;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
`ifdef QUAD_MIN_LOADER_CHECK_EN
                    chk_err_q   <= |gt_vec;
`endif
                end
                HOLD: begin
                    // Re-open the input only on the edge after the result is taken.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                default: begin
                    state_q    <= FILL;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_min   = out_min_q;
    assign a         = smp_q[0];
    assign b         = smp_q[1];
    assign c         = smp_q[2];
    assign d         = smp_q[3];

endmodule

// File: tb/tb_quad_min_loader.sv
// Bench for quad_min_loader: a behavioural returnmin (lowest index wins ties) drives minidx_in.
module tb_quad_min_loader;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] a, b, c, d;
    logic [1:0]   minidx_in;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_idx;
    logic [W-1:0] out_min;
`ifdef QUAD_MIN_LOADER_CHECK_EN
    logic         chk_err;
`endif

    quad_min_loader #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a(a), .b(b), .c(c), .d(d),
        .minidx_in(minidx_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx),
`ifdef QUAD_MIN_LOADER_CHECK_EN
        .out_min(out_min),
        .chk_err(chk_err)
`else
        .out_min(out_min)
`endif
    );

    always #5 clk = ~clk;

    // Reference returnmin, with an override path for forcing a bad index.
    logic [1:0]   rm_idx;
    logic [W-1:0] rm_min;
    logic         ov_en = 1'b0;
    logic [1:0]   ov_idx = 2'd0;
    always_comb begin
        rm_idx = 2'd0;
        rm_min = a;
        if (b < rm_min) begin rm_idx = 2'd1; rm_min = b; end
        if (c < rm_min) begin rm_idx = 2'd2; rm_min = c; end
        if (d < rm_min) begin rm_idx = 2'd3; rm_min = d; end
    end
    assign minidx_in = ov_en ? ov_idx : rm_idx;

    typedef struct { int idx; int mn; } exp_t;
    typedef struct {
        int s[4];
        bit gap;
        int stall;
        bit nowait;
        int exp_idx;
        int exp_min;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    vec_t tbl[5];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_hs = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Output side of the scoreboard: pop on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("out_idx", int'(out_idx), sb_e.idx);
                chk("out_min", int'(out_min), sb_e.mn);
                $display("result idx=%0d min=%0d at edge %0d", out_idx, out_min, cyc + 1);
            end
            last_hs = cyc + 1;
        end
    end

    task automatic send_sample(int v, bit first);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v[W-1:0];
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
        else if (first) chk("accept_after_handshake", int'(cyc > last_hs), 1);
    endtask

    task automatic run_group(int s0, int s1, int s2, int s3, bit gap, int stall,
                             bit nowait, int ei, int em);
        int s[4];
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        out_ready = (stall == 0);
        for (int i = 0; i < 4; i++) begin
            if (gap && i > 0) begin
                in_data = 3'($urandom_range(0, 7));
                @(posedge clk);
                #1;
            end
            send_sample(s[i], i == 0);
        end
        e.idx = ei;
        e.mn  = em;
        sb_q.push_back(e);
        $display("group %0d,%0d,%0d,%0d accepted at edge %0d", s0, s1, s2, s3, cyc);
        if (nowait) return;
        @(negedge clk);
        chk("eval_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("hold_out_valid", int'(out_valid), 1);
        chk("reg_a", int'(a), s0);
        chk("reg_b", int'(b), s1);
        chk("reg_c", int'(c), s2);
        chk("reg_d", int'(d), s3);
        for (int j = 0; j < stall; j++) begin
            in_valid = 1'b1;
            in_data  = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_regs", int'({a, b, c, d}), int'({s[0][2:0], s[1][2:0], s[2][2:0], s[3][2:0]}));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (stall > 0) chk("stall_regs_end", int'({a, b, c, d}),
                           int'({s[0][2:0], s[1][2:0], s[2][2:0], s[3][2:0]}));
        @(posedge clk);
        #1;
        chk("post_hs_out_valid", int'(out_valid), 0);
        chk("post_hs_in_ready", int'(in_ready), 1);
    endtask

    task automatic set_vec(int k, int s0, int s1, int s2, int s3, bit gap, int stall,
                           bit nowait, int ei, int em);
        tbl[k].s[0] = s0; tbl[k].s[1] = s1; tbl[k].s[2] = s2; tbl[k].s[3] = s3;
        tbl[k].gap = gap; tbl[k].stall = stall; tbl[k].nowait = nowait;
        tbl[k].exp_idx = ei; tbl[k].exp_min = em;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, 2, 1, 2, 3, 1'b0, 0, 1'b0, 1, 1);
        set_vec(1, 4, 1, 6, 3, 1'b0, 5, 1'b0, 1, 1);
        set_vec(2, 7, 7, 6, 2, 1'b1, 0, 1'b0, 3, 2);
        set_vec(3, 5, 1, 6, 7, 1'b0, 0, 1'b1, 1, 1);
        set_vec(4, 4, 5, 5, 5, 1'b0, 0, 1'b0, 0, 4);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_regs", int'({a, b, c, d}), 0);
        chk("rst_out", int'({out_idx, out_min}), 0);

        for (int k = 0; k < 5; k++) begin
            run_group(tbl[k].s[0], tbl[k].s[1], tbl[k].s[2], tbl[k].s[3], tbl[k].gap,
                      tbl[k].stall, tbl[k].nowait, tbl[k].exp_idx, tbl[k].exp_min);
        end

        // Reset in the middle of FILL discards the partial group.
        send_sample(5, 1'b1);
        send_sample(3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_regs", int'({a, b, c, d}), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out", int'({out_idx, out_min}), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        run_group(2, 3, 0, 2, 1'b0, 0, 1'b0, 2, 0);

`ifdef QUAD_MIN_LOADER_CHECK_EN
        ov_en = 1'b1;
        ov_idx = 2'd0;
        run_group(3, 1, 2, 3, 1'b0, 0, 1'b1, 0, 3);
        @(posedge clk);
        #1;
        chk("chk_err_set", int'(chk_err), 1);
        ov_en = 1'b0;
        run_group(4, 2, 5, 6, 1'b0, 0, 1'b1, 1, 2);
        @(posedge clk);
        #1;
        chk("chk_err_clear", int'(chk_err), 0);
`endif

        for (int n = 0; n < 20 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
